// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception/interrupt controller.
// The priority decision lives here so it can be reused by any datapath variant.
package exc_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } state_t;

    localparam logic [3:0] ESR_UNDEF   = 4'b0001;
    localparam logic [3:0] ESR_IRQ     = 4'b0010;
    localparam logic [3:0] ESR_BADERET = 4'b0011;
    localparam logic [3:0] ESR_DFAULT  = 4'b1111;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_VEC = 2'b01;
    localparam logic [1:0] PCSEL_ELR = 2'b10;

    localparam logic [1:0] SYSREG_ELR   = 2'b00;
    localparam logic [1:0] SYSREG_ESR   = 2'b01;
    localparam logic [1:0] SYSREG_STATE = 2'b10;
    localparam logic [1:0] SYSREG_ZERO  = 2'b11;

    typedef struct packed {
        logic       take;
        logic       ret;
        logic       irq_take;
        logic       hold_elr;
        logic [3:0] cause;
    } exc_dec_t;

    // Priority: undefined opcode, then ERET, then a pending IRQ (only outside the handler).
    function automatic exc_dec_t decide(input state_t st, input logic nai,
                                        input logic eret, input logic pend);
        exc_dec_t d;
        d = '0;
        if (nai) begin
            d.take = 1'b1;
            if (st == HANDLER) begin
                d.cause    = ESR_DFAULT;
                d.hold_elr = 1'b1;
            end else begin
                d.cause = ESR_UNDEF;
            end
        end else if (eret) begin
            if (st == HANDLER) begin
                d.ret = 1'b1;
            end else begin
                d.take  = 1'b1;
                d.cause = ESR_BADERET;
            end
        end else if (pend && (st == IDLE)) begin
            d.take     = 1'b1;
            d.irq_take = 1'b1;
            d.cause    = ESR_IRQ;
        end else begin
            d = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Datapath-side bundle of the exception controller: decoder flags and PC in,
// PC steering, squash and system-register view out.
interface exc_ctrl_if #(
    parameter int N = 64
);
    logic [N-1:0] PC_i;
    logic         NotAnInstr;
    logic         ERet;
    logic         ExtIRQ;
    logic [1:0]   SysRegSel;
    logic [1:0]   PCSel;
    logic         ExcTaken;
    logic [N-1:0] ExcVector;
    logic [N-1:0] ELR;
    logic [3:0]   ESR;
    logic         ExcAck;
    logic [N-1:0] SysRegData;

    modport master (
        output PC_i, NotAnInstr, ERet, ExtIRQ, SysRegSel,
        input  PCSel, ExcTaken, ExcVector, ELR, ESR, ExcAck, SysRegData
    );

    modport slave (
        input  PC_i, NotAnInstr, ERet, ExtIRQ, SysRegSel,
        output PCSel, ExcTaken, ExcVector, ELR, ESR, ExcAck, SysRegData
    );
endinterface

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the external interrupt line with a rising-edge
// detect on the synchronized level.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);
    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s2_d;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller for the single-cycle LEGv8 datapath: decides
// exception entry/return each cycle and holds ELR, ESR and handler state.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int           N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = 64'hD8
) (
    input  logic      clk,
    input  logic      reset,
    exc_ctrl_if.slave bus
);
    state_t       r_state;
    logic [N-1:0] r_elr;
    logic [3:0]   r_esr;
    logic         r_pending;
    logic         r_ack;
    logic         w_rise;
    exc_dec_t     w_dec;
    logic [1:0]   w_pcsel;
    logic [N-1:0] w_sysreg;

    irq_sync u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.ExtIRQ),
        .o_rise  (w_rise)
    );

    // Exception decision; forced idle while reset is held so nothing is squashed.
    always_comb begin
        w_dec = '0;
        if (reset) begin
            w_dec = '0;
        end else begin
            w_dec = decide(r_state, bus.NotAnInstr, bus.ERet, r_pending);
        end
    end

    // Next-PC source select.
    always_comb begin
        w_pcsel = PCSEL_SEQ;
        if (w_dec.take) begin
            w_pcsel = PCSEL_VEC;
        end else if (w_dec.ret) begin
            w_pcsel = PCSEL_ELR;
        end else begin
            w_pcsel = PCSEL_SEQ;
        end
    end

    // MRS read mux, showing register values before this cycle's update.
    always_comb begin
        w_sysreg = '0;
        case (bus.SysRegSel)
            SYSREG_ELR:   w_sysreg = r_elr;
            SYSREG_ESR:   w_sysreg = {{(N-4){1'b0}}, r_esr};
            SYSREG_STATE: w_sysreg = {{(N-1){1'b0}}, (r_state == HANDLER)};
            SYSREG_ZERO:  w_sysreg = '0;
            default:      w_sysreg = '0;
        endcase
    end

    // Handler FSM with ELR/ESR capture, IRQ pending latch and acknowledge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_elr     <= '0;
            r_esr     <= 4'b0000;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_dec.irq_take;
            // A fresh edge arriving as the old request is taken stays pending.
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (w_dec.irq_take) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
            if (w_dec.take) begin
                r_state <= HANDLER;
                r_esr   <= w_dec.cause;
                // Double fault keeps the original return address.
                if (!w_dec.hold_elr) begin
                    r_elr <= bus.PC_i;
                end else begin
                    r_elr <= r_elr;
                end
            end else if (w_dec.ret) begin
                r_state <= IDLE;
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign bus.PCSel      = w_pcsel;
    assign bus.ExcTaken   = w_dec.take;
    assign bus.ExcVector  = EXC_VECTOR;
    assign bus.ELR        = r_elr;
    assign bus.ESR        = r_esr;
    assign bus.ExcAck     = r_ack;
    assign bus.SysRegData = w_sysreg;

endmodule
